// File: rtl/blake_pad_framer.sv
// blake_pad_framer: packs an IN_W-bit message stream into 1024-bit BLAKE-512
// blocks with 0x80 / 0x01 / 128-bit length padding and per-block counter t.
`default_nettype none

module blake_pad_framer #(
   parameter int IN_W  = 64,
   parameter int BSWAP = 1,
   parameter int LEN_W = 64
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [IN_W-1:0]           in_data,
   input  logic                      in_last,
   input  logic [$clog2(IN_W/8):0]   in_bytes,
   output logic                      blk_valid,
   input  logic                      blk_ready,
   output logic [1023:0]             blk_data,
   output logic [127:0]              blk_cnt,
   output logic                      blk_last
);

   localparam int BPW   = IN_W / 8;
   localparam int NSLOT = 1024 / IN_W;
   localparam int KW    = $clog2(BPW) + 1;

   localparam logic [1023:0] C_TOP80  = {8'h80, 1016'd0};
   localparam logic [1023:0] C_MARK01 = {888'd0, 8'h01, 128'd0};

   typedef enum logic [1:0] {
      S_FILL       = 2'd0,
      S_EMIT_DATA  = 2'd1,
      S_EMIT_FINAL = 2'd2,
      S_EMIT_PAD   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [1023:0]     buf_q, buf_d;
   logic [7:0]        n_q, n_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [1023:0]     blk_data_q, blk_data_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              pend_q, pend_d;
   logic              pmode_q, pmode_d;

   logic [IN_W-1:0]   w_sw;
   logic [IN_W-1:0]   w_word;
   logic [KW-1:0]     w_k;
   logic [7:0]        w_n_new;
   logic [LEN_W-1:0]  w_len_new;
   logic [1023:0]     w_fill;
   logic [1023:0]     w_mark;
   logic [127:0]      w_len128_new;
   logic [127:0]      w_len128_q;

   generate
      if (BSWAP != 0) begin : g_bswap
         for (genvar l = 0; l < IN_W / 32; l++) begin : g_lane
            assign w_sw[32*l +: 32] = {in_data[32*l +: 8], in_data[32*l+8 +: 8],
                                       in_data[32*l+16 +: 8], in_data[32*l+24 +: 8]};
         end
      end else begin : g_nobswap
         assign w_sw = in_data;
      end
   endgenerate

   // Word insertion: non-last words are always full, so n is slot-aligned.
   always_comb begin
      w_k = in_last ? in_bytes : KW'(BPW);
      for (int j = 0; j < BPW; j++) begin
         w_word[IN_W-1-8*j -: 8] = (KW'(j) < w_k) ? w_sw[IN_W-1-8*j -: 8] : 8'h00;
      end
      w_fill = buf_q;
      for (int s = 0; s < NSLOT; s++) begin
         if (n_q == 8'(s * BPW)) begin
            w_fill[1023-s*IN_W -: IN_W] = w_word;
         end
      end
      w_n_new   = n_q + 8'(w_k);
      w_len_new = len_q + (LEN_W'(w_k) << 3);
      w_mark    = C_TOP80 >> {w_n_new, 3'b000};
      w_len128_new = '0;
      w_len128_new[LEN_W-1:0] = w_len_new;
      w_len128_q = '0;
      w_len128_q[LEN_W-1:0] = len_q;
   end

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      n_d        = n_q;
      len_d      = len_q;
      blk_data_d = blk_data_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      pend_d     = pend_q;
      pmode_d    = pmode_q;
      case (state_q)
         S_FILL: begin
            if (in_valid) begin
               buf_d = w_fill;
               n_d   = w_n_new;
               len_d = w_len_new;
               if (in_last) begin
                  buf_d = '0;
                  n_d   = '0;
                  if (w_n_new <= 8'd111) begin
                     blk_data_d = w_fill | w_mark | C_MARK01 | {896'd0, w_len128_new};
                     cnt_d      = (w_n_new != 8'd0) ? w_len_new : '0;
                     last_d     = 1'b1;
                     state_d    = S_EMIT_FINAL;
                  end else begin
                     // Length does not fit: data block now, padding block next.
                     blk_data_d = w_fill | w_mark;
                     cnt_d      = w_len_new;
                     last_d     = 1'b0;
                     pend_d     = 1'b1;
                     pmode_d    = (w_n_new == 8'd128);
                     state_d    = S_EMIT_DATA;
                  end
               end else if (w_n_new == 8'd128) begin
                  buf_d      = '0;
                  n_d        = '0;
                  blk_data_d = w_fill;
                  cnt_d      = w_len_new;
                  last_d     = 1'b0;
                  pend_d     = 1'b0;
                  state_d    = S_EMIT_DATA;
               end
            end
         end
         S_EMIT_DATA: begin
            if (blk_ready) begin
               if (pend_q) begin
                  blk_data_d = C_MARK01 | {896'd0, w_len128_q} | (pmode_q ? C_TOP80 : '0);
                  cnt_d      = '0;
                  last_d     = 1'b1;
                  pend_d     = 1'b0;
                  state_d    = S_EMIT_PAD;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         default: begin
            if (blk_ready) begin
               state_d = S_FILL;
               len_d   = '0;
               n_d     = '0;
               buf_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q    <= S_FILL;
         buf_q      <= '0;
         n_q        <= '0;
         len_q      <= '0;
         blk_data_q <= '0;
         cnt_q      <= '0;
         last_q     <= 1'b0;
         pend_q     <= 1'b0;
         pmode_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         n_q        <= n_d;
         len_q      <= len_d;
         blk_data_q <= blk_data_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         pend_q     <= pend_d;
         pmode_q    <= pmode_d;
      end
   end

   always_comb begin
      blk_cnt = '0;
      blk_cnt[LEN_W-1:0] = cnt_q;
   end

   assign in_ready  = (state_q == S_FILL);
   assign blk_valid = (state_q != S_FILL);
   assign blk_data  = blk_data_q;
   assign blk_last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_blake_pad_framer.sv
// tb_blake_pad_framer: random messages checked against a byte-level BLAKE-512
// padding model (pad, split into blocks, count message bits per block).
`default_nettype none

module tb_blake_pad_framer;

   logic          clk = 1'b0;
   logic          rstb;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_data;
   logic          in_last;
   logic [3:0]    in_bytes;
   logic          blk_valid;
   logic          blk_ready;
   logic [1023:0] blk_data;
   logic [127:0]  blk_cnt;
   logic          blk_last;

   int nvec  = 0;
   int nfail = 0;

   byte unsigned  msg[$];
   byte unsigned  hdr[$];
   logic [63:0]   wq[$];
   logic [3:0]    bq[$];
   bit            lq[$];
   logic [1023:0] exp_data[$];
   logic [127:0]  exp_cnt[$];
   bit            exp_last[$];

   blake_pad_framer #(.IN_W(64), .BSWAP(1), .LEN_W(64)) dut (
      .clk       (clk),
      .rstb      (rstb),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_bytes  (in_bytes),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_cnt   (blk_cnt),
      .blk_last  (blk_last)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] lswap(input logic [63:0] w);
      return {w[39:32], w[47:40], w[55:48], w[63:56], w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Word stream and expected blocks for the message in msg[].
   task automatic build(input bit extra_empty);
      int M, nfull, rem, nw, nb;
      byte unsigned pad[$];
      logic [127:0] L;
      M = msg.size();
      nfull = M / 8;
      rem = M % 8;
      wq.delete(); bq.delete(); lq.delete();
      exp_data.delete(); exp_cnt.delete(); exp_last.delete();
      nw = (extra_empty || rem != 0 || M == 0) ? nfull + 1 : nfull;
      for (int w = 0; w < nw; w++) begin
         logic [63:0] ww;
         for (int j = 0; j < 8; j++) begin
            int idx;
            idx = 8 * w + j;
            ww[63-8*j -: 8] = (idx < M) ? msg[idx] : 8'($urandom);
         end
         wq.push_back(lswap(ww));
         lq.push_back(w == nw - 1);
         if (w == nw - 1) bq.push_back(4'(M - 8 * w));
         else             bq.push_back(4'($urandom));
      end
      pad = msg;
      pad.push_back(8'h80);
      while (pad.size() % 128 != 112) pad.push_back(8'h00);
      pad[pad.size() - 1] = pad[pad.size() - 1] | 8'h01;
      L = {64'd0, 64'(M * 8)};
      for (int k = 15; k >= 0; k--) pad.push_back(8'(L >> (8 * k)));
      nb = pad.size() / 128;
      for (int i = 0; i < nb; i++) begin
         logic [1023:0] d;
         int upto;
         for (int b = 0; b < 128; b++) d[1023-8*b -: 8] = pad[128*i+b];
         upto = (M < 128 * (i + 1)) ? M : 128 * (i + 1);
         exp_data.push_back(d);
         exp_cnt.push_back((M > 128 * i) ? {64'd0, 64'(upto * 8)} : 128'd0);
         exp_last.push_back(i == nb - 1);
      end
   endtask

   task automatic rand_msg(input int M);
      msg.delete();
      for (int i = 0; i < M; i++) msg.push_back(8'($urandom));
   endtask

   // Drives the word stream and consumes blocks, checking every valid cycle.
   task automatic run(input string name, input bit stall);
      int wi, bi, sc, cyc;
      wi = 0; bi = 0; sc = 0; cyc = 0;
      while ((wi < wq.size() || bi < exp_data.size()) && cyc < 20000) begin
         in_valid  = (wi < wq.size()) && ($urandom_range(3) != 0);
         in_data   = (wi < wq.size()) ? wq[wi] : 64'($urandom);
         in_bytes  = (wi < wq.size()) ? bq[wi] : 4'd0;
         in_last   = in_valid ? lq[wi] : 1'b0;
         blk_ready = stall ? (sc >= 5) : ($urandom_range(3) != 0);
         nvec++;
         if (in_ready !== !blk_valid) begin
            nfail++;
            $display("FAIL %s in_ready: got %b want %b", name, in_ready, !blk_valid);
         end
         if (blk_valid === 1'b1) begin
            nvec++;
            if (bi >= exp_data.size()) begin
               nfail++;
               $display("FAIL %s extra_block: got block %0d want none", name, bi);
            end else begin
               if (blk_data !== exp_data[bi]) begin
                  int fb;
                  fb = 0;
                  for (int b = 127; b >= 0; b--)
                     if (blk_data[1023-8*b -: 8] !== exp_data[bi][1023-8*b -: 8]) fb = b;
                  nfail++;
                  $display("FAIL %s blk%0d data byte %0d: got %h want %h", name, bi, fb,
                           blk_data[1023-8*fb -: 8], exp_data[bi][1023-8*fb -: 8]);
               end
               nvec++;
               if (blk_cnt !== exp_cnt[bi]) begin
                  nfail++;
                  $display("FAIL %s blk%0d cnt: got %h want %h", name, bi, blk_cnt, exp_cnt[bi]);
               end
               nvec++;
               if (blk_last !== exp_last[bi]) begin
                  nfail++;
                  $display("FAIL %s blk%0d last: got %b want %b", name, bi, blk_last, exp_last[bi]);
               end
            end
            if (blk_ready) begin bi++; sc = 0; end
            else sc++;
         end
         if (in_valid && in_ready) wi++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
      nvec++;
      if (cyc >= 20000) begin
         nfail++;
         $display("FAIL %s timeout: got %0d words %0d blocks want %0d %0d",
                  name, wi, bi, wq.size(), exp_data.size());
      end
      nvec++;
      if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
         nfail++;
         $display("FAIL %s idle_after: got valid=%b ready=%b want 0 1", name, blk_valid, in_ready);
      end
   endtask

   task automatic test_reset;
      rstb = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_bytes = '0; blk_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_data !== '0 || blk_cnt !== '0 || blk_last !== 1'b0) begin
         nfail++;
         $display("FAIL reset outputs: got rdy=%b vld=%b cnt=%h last=%b want 1 0 0 0",
                  in_ready, blk_valid, blk_cnt, blk_last);
      end
      rstb = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_header;
      hdr.delete();
      for (int i = 0; i < 80; i++) hdr.push_back(8'($urandom));
      msg = hdr;
      build(1'b0);
      run("header80", 1'b0);
   endtask

   task automatic test_lengths;
      int lens[6] = '{0, 111, 112, 127, 128, 256};
      foreach (lens[i]) begin
         rand_msg(lens[i]);
         build(1'b0);
         run($sformatf("len%0d", lens[i]), 1'b0);
      end
      rand_msg(128);
      build(1'b1);
      run("len128_empty_last", 1'b0);
   endtask

   task automatic test_stall;
      rand_msg(300);
      build(1'b0);
      run("stall300", 1'b1);
   endtask

   task automatic test_back_to_back;
      for (int t = 0; t < 10; t++) begin
         int M;
         bit ee;
         M = $urandom_range(400);
         ee = (M % 8 == 0) && ($urandom_range(1) == 1);
         rand_msg(M);
         build(ee);
         run($sformatf("rand%0d_len%0d", t, M), t % 3 == 0);
      end
   endtask

   task automatic test_reset_mid;
      int cyc;
      cyc = 0;
      blk_ready = 1'b0;
      in_last = 1'b0;
      in_bytes = 4'd8;
      while (blk_valid !== 1'b1 && cyc < 200) begin
         in_valid = 1'b1;
         in_data = 64'({$urandom, $urandom});
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      nvec++;
      if (blk_valid !== 1'b1) begin
         nfail++;
         $display("FAIL reset_mid reach_emit: got valid=%b want 1", blk_valid);
      end
      rstb = 1'b0;
      @(posedge clk); #1;
      nvec++;
      if (blk_valid !== 1'b0 || in_ready !== 1'b1 || blk_cnt !== '0 || blk_last !== 1'b0) begin
         nfail++;
         $display("FAIL reset_mid outputs: got vld=%b rdy=%b cnt=%h want 0 1 0",
                  blk_valid, in_ready, blk_cnt);
      end
      rstb = 1'b1;
      @(posedge clk); #1;
      msg = hdr;
      build(1'b0);
      run("reset_mid_header80", 1'b0);
   endtask

   initial begin
      test_reset();
      test_header();
      test_lengths();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

`default_nettype wire
